ascon_aead_seq: RTL and testbench

ASCON_AEAD_SEQ -- requirements
Module: ascon_aead_seq

---
 rtl/ascon_pkg.sv | 30 +++
 rtl/compteur_Nbits.sv | 28 ++
 rtl/ascon_aead_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_ascon_aead_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared widths and sequencer state encoding for the ascon AEAD sequencer
// Contents: BLOCK_W/TAG_W/KEY_W widths, seq_state_t FSM encoding, max_int helper.
// Optional: ASCON_SEQ_WATCHDOG_EN adds the ST_ERR state.
package ascon_pkg;

  localparam int BLOCK_W = 64;
  localparam int TAG_W   = 128;
  localparam int KEY_W   = 128;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_AD_SET,
    ST_AD_NEXT,
    ST_PT_SET,
    ST_PT_GET,
    ST_PT_WAIT,
    ST_FINAL,
    ST_DONE
`ifdef ASCON_SEQ_WATCHDOG_EN
    ,
    ST_ERR
`endif
  } seq_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/compteur_Nbits.sv
// rtl/compteur_Nbits.sv - clearable up-counter used as the block index
// Ports: i_clk (clock), i_resetn (sync active-low reset), i_clear (synchronous clear,
//        wins over i_incr), i_incr (count up by one), o_count (current value).
module compteur_Nbits #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_clear,
  input  logic             i_incr,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_incr) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/ascon_aead_seq.sv
// rtl/ascon_aead_seq.sv - sequences one ascon AEAD encryption through an external core
// Ports: clock_i/reset_i (sync active-low); start_i; plain_text_i/da_i (packed 64-bit blocks);
//        core side: init_o, associate_data_o, finalisation_o, data_valid_o, data_o out,
//        end_initialisation_i, end_associate_i, cipher_valid_i, end_cipher_i, end_tag_i,
//        cipher_i, tag_i in; results: cipher_o, tag_o, busy_o, done_o.
// Optional: ASCON_SEQ_WATCHDOG_EN adds error_o and a per-handshake timeout into ST_ERR.
module ascon_aead_seq
  import ascon_pkg::*;
#(
  parameter int N_PT_BLOCKS = 23,
  parameter int N_AD_BLOCKS = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic                           start_i,
  input  logic [BLOCK_W*N_PT_BLOCKS-1:0] plain_text_i,
  input  logic [BLOCK_W*N_AD_BLOCKS-1:0] da_i,
  output logic                           init_o,
  output logic                           associate_data_o,
  output logic                           finalisation_o,
  output logic                           data_valid_o,
  output logic [BLOCK_W-1:0]             data_o,
  input  logic                           end_initialisation_i,
  input  logic                           end_associate_i,
  input  logic                           cipher_valid_i,
  input  logic                           end_cipher_i,
  input  logic                           end_tag_i,
  input  logic [BLOCK_W-1:0]             cipher_i,
  input  logic [TAG_W-1:0]               tag_i,
  output logic [BLOCK_W*N_PT_BLOCKS-1:0] cipher_o,
  output logic [TAG_W-1:0]               tag_o,
  output logic                           busy_o,
  output logic                           done_o
`ifdef ASCON_SEQ_WATCHDOG_EN
  ,
  output logic                           error_o
`endif
);

  localparam int IDX_W = $clog2(max_int(N_PT_BLOCKS, N_AD_BLOCKS)) + 1;
  localparam logic [IDX_W-1:0] AD_LAST    = IDX_W'(N_AD_BLOCKS - 1);
  // Index of the block before the last one; the last block is always sent in FINAL.
  localparam logic [IDX_W-1:0] PT_PRELAST = IDX_W'(N_PT_BLOCKS - 2);

  if (N_PT_BLOCKS < 1 || N_PT_BLOCKS > 64 || N_AD_BLOCKS < 1 || N_AD_BLOCKS > 16 ||
      TIMEOUT_CYC < 1) begin : g_param_check
    $error("ascon_aead_seq: parameter out of range");
  end

  seq_state_t                     r_state;
  seq_state_t                     w_next;
  logic [BLOCK_W*N_PT_BLOCKS-1:0] r_cipher;
  logic [TAG_W-1:0]               r_tag;
  logic [IDX_W-1:0]               w_idx;
  logic                           w_idx_clr;
  logic                           w_idx_inc;
  logic                           w_clear;
  logic                           w_ct_wr;
  logic                           w_ct_last;
  logic                           w_tag_wr;
  logic [BLOCK_W-1:0]             w_pt_blk;
  logic [BLOCK_W-1:0]             w_ad_blk;
  logic [BLOCK_W-1:0]             w_pt_last;

  compteur_Nbits #(
    .WIDTH(IDX_W)
  ) u_idx (
    .i_clk   (clock_i),
    .i_resetn(reset_i),
    .i_clear (w_idx_clr),
    .i_incr  (w_idx_inc),
    .o_count (w_idx)
  );

  // Block selection by comparison rather than a variable part-select keeps the
  // index width independent of the packed vector width.
  always_comb begin
    w_pt_blk = '0;
    w_ad_blk = '0;
    for (int k = 0; k < N_PT_BLOCKS; k++) begin
      if (w_idx == IDX_W'(k)) w_pt_blk = plain_text_i[k*BLOCK_W +: BLOCK_W];
    end
    for (int k = 0; k < N_AD_BLOCKS; k++) begin
      if (w_idx == IDX_W'(k)) w_ad_blk = da_i[k*BLOCK_W +: BLOCK_W];
    end
  end

  assign w_pt_last = plain_text_i[(N_PT_BLOCKS-1)*BLOCK_W +: BLOCK_W];

`ifdef ASCON_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
  logic [WD_W-1:0] r_wd_cnt;
  logic            w_waiting;

  assign w_waiting = (r_state == ST_INIT) || (r_state == ST_AD_SET) ||
                     (r_state == ST_PT_SET) || (r_state == ST_PT_WAIT) ||
                     (r_state == ST_FINAL);

  // Counts cycles spent in the current state; any state change restarts it.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      r_wd_cnt <= '0;
    end else if (w_next != r_state) begin
      r_wd_cnt <= '0;
    end else if (r_wd_cnt != '1) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
  end

  assign error_o = (r_state == ST_ERR);
`endif

  always_comb begin
    w_next           = r_state;
    w_idx_clr        = 1'b0;
    w_idx_inc        = 1'b0;
    w_clear          = 1'b0;
    w_ct_wr          = 1'b0;
    w_ct_last        = 1'b0;
    w_tag_wr         = 1'b0;
    init_o           = 1'b0;
    associate_data_o = 1'b0;
    finalisation_o   = 1'b0;
    data_valid_o     = 1'b0;
    data_o           = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_next    = ST_INIT;
          w_clear   = 1'b1;
          w_idx_clr = 1'b1;
        end
      end
      ST_INIT: begin
        init_o = 1'b1;
        if (end_initialisation_i) w_next = ST_AD_SET;
      end
      ST_AD_SET: begin
        associate_data_o = 1'b1;
        data_valid_o     = 1'b1;
        data_o           = w_ad_blk;
        if (end_associate_i) w_next = ST_AD_NEXT;
      end
      ST_AD_NEXT: begin
        if (w_idx == AD_LAST) begin
          w_idx_clr = 1'b1;
          w_next    = (N_PT_BLOCKS == 1) ? ST_FINAL : ST_PT_SET;
        end else begin
          w_idx_inc = 1'b1;
          w_next    = ST_AD_SET;
        end
      end
      ST_PT_SET: begin
        data_valid_o = 1'b1;
        data_o       = w_pt_blk;
        if (cipher_valid_i) w_next = ST_PT_GET;
      end
      ST_PT_GET: begin
        w_ct_wr = 1'b1;
        w_next  = ST_PT_WAIT;
      end
      ST_PT_WAIT: begin
        if (end_cipher_i) begin
          w_idx_inc = 1'b1;
          w_next    = (w_idx == PT_PRELAST) ? ST_FINAL : ST_PT_SET;
        end
      end
      ST_FINAL: begin
        finalisation_o = 1'b1;
        data_valid_o   = 1'b1;
        data_o         = w_pt_last;
        w_ct_last      = cipher_valid_i;
        if (end_tag_i) begin
          w_tag_wr = 1'b1;
          w_next   = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
`ifdef ASCON_SEQ_WATCHDOG_EN
      ST_ERR: begin
        if (start_i) begin
          w_next    = ST_INIT;
          w_clear   = 1'b1;
          w_idx_clr = 1'b1;
        end
      end
`endif
      default: begin
        w_next = ST_IDLE;
      end
    endcase
`ifdef ASCON_SEQ_WATCHDOG_EN
    // A handshake that arrives on the last allowed cycle still wins over the timeout.
    if (w_waiting && (w_next == r_state) && (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1))) begin
      w_next    = ST_ERR;
      w_ct_last = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      r_state  <= ST_IDLE;
      r_cipher <= '0;
      r_tag    <= '0;
    end else begin
      r_state <= w_next;
      if (w_clear) begin
        r_cipher <= '0;
        r_tag    <= '0;
      end else begin
        for (int k = 0; k < N_PT_BLOCKS; k++) begin
          if (w_ct_wr && (w_idx == IDX_W'(k))) r_cipher[k*BLOCK_W +: BLOCK_W] <= cipher_i;
        end
        if (w_ct_last) r_cipher[(N_PT_BLOCKS-1)*BLOCK_W +: BLOCK_W] <= cipher_i;
        if (w_tag_wr) r_tag <= tag_i;
      end
    end
  end

  assign cipher_o = r_cipher;
  assign tag_o    = r_tag;
  assign busy_o   = (r_state != ST_IDLE);
  assign done_o   = (r_state == ST_DONE);

endmodule

// File: tb/tb_ascon_aead_seq.sv
// tb/tb_ascon_aead_seq.sv - directed self-checking bench for ascon_aead_seq (N_PT=3, N_AD=2)
module tb_ascon_aead_seq;

  localparam int          NPT = 3;
  localparam int          NAD = 2;
  localparam logic [63:0] PAT = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [127:0] TAG1 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
  localparam logic [127:0] TAG2 = 128'h0000_0000_0000_0000_0000_0000_0000_0001;

  logic              clock_i = 1'b0;
  logic              reset_i;
  logic              start_i;
  logic [64*NPT-1:0] plain_text_i;
  logic [64*NAD-1:0] da_i;
  logic              init_o, associate_data_o, finalisation_o, data_valid_o;
  logic [63:0]       data_o;
  logic              end_initialisation_i, end_associate_i, cipher_valid_i;
  logic              end_cipher_i, end_tag_i;
  logic [63:0]       cipher_i;
  logic [127:0]      tag_i;
  logic [64*NPT-1:0] cipher_o;
  logic [127:0]      tag_o;
  logic              busy_o, done_o;
`ifdef ASCON_SEQ_WATCHDOG_EN
  logic              error_o;
`endif

  always #5 clock_i = ~clock_i;

  ascon_aead_seq #(
    .N_PT_BLOCKS(NPT),
    .N_AD_BLOCKS(NAD),
    .TIMEOUT_CYC(16)
  ) dut (
    .clock_i             (clock_i),
    .reset_i             (reset_i),
    .start_i             (start_i),
    .plain_text_i        (plain_text_i),
    .da_i                (da_i),
    .init_o              (init_o),
    .associate_data_o    (associate_data_o),
    .finalisation_o      (finalisation_o),
    .data_valid_o        (data_valid_o),
    .data_o              (data_o),
    .end_initialisation_i(end_initialisation_i),
    .end_associate_i     (end_associate_i),
    .cipher_valid_i      (cipher_valid_i),
    .end_cipher_i        (end_cipher_i),
    .end_tag_i           (end_tag_i),
    .cipher_i            (cipher_i),
    .tag_i               (tag_i),
    .cipher_o            (cipher_o),
    .tag_o               (tag_o),
    .busy_o              (busy_o),
    .done_o              (done_o)
`ifdef ASCON_SEQ_WATCHDOG_EN
    ,
    .error_o             (error_o)
`endif
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          done_seen = 0;
  logic [63:0] exp_ct [NPT];

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
    if (done_o) done_seen++;
  endtask

  function automatic bit cond(input int w);
    case (w)
      0:       return init_o;
      1:       return associate_data_o;
      2:       return data_valid_o && !associate_data_o && !finalisation_o;
      3:       return finalisation_o;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int w, input string tag);
    int n = 0;
    while (!cond(w) && n < 40) begin
      step();
      n++;
    end
    check(tag, cond(w), 1);
  endtask

  task automatic start_op();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  // Behavioural core: echoes the presented block XOR PAT as ciphertext.
  // stop_blk >= 0 returns while the sequencer sits in PT_WAIT of that block.
  task automatic serve(input logic [127:0] tg, input bit coincide, input bit poke, input int stop_blk);
    wait_for(0, "init_o");
    end_initialisation_i = 1'b1;
    step();
    end_initialisation_i = 1'b0;
    for (int a = 0; a < NAD; a++) begin
      wait_for(1, "ad_set");
      check("ad_data", data_o, da_i[64*a +: 64]);
      if (poke && a == 1) start_i = 1'b1;
      end_associate_i = 1'b1;
      step();
      end_associate_i = 1'b0;
      start_i = 1'b0;
    end
    for (int b = 0; b < NPT - 1; b++) begin
      wait_for(2, "pt_set");
      check("pt_data", data_o, plain_text_i[64*b +: 64]);
      cipher_i = data_o ^ PAT;
      cipher_valid_i = 1'b1;
      step();
      cipher_valid_i = 1'b0;
      step();
      check("ct_blk_write", cipher_o[64*b +: 64], exp_ct[b]);
      if (b == stop_blk) return;
      end_cipher_i = 1'b1;
      step();
      end_cipher_i = 1'b0;
    end
    wait_for(3, "final");
    check("final_data", data_o, plain_text_i[64*(NPT-1) +: 64]);
    cipher_i = data_o ^ PAT;
    cipher_valid_i = 1'b1;
    if (coincide) begin
      tag_i = tg;
      end_tag_i = 1'b1;
      step();
      cipher_valid_i = 1'b0;
      end_tag_i = 1'b0;
    end else begin
      step();
      cipher_valid_i = 1'b0;
      cipher_i = 64'hDEAD_DEAD_DEAD_DEAD;
      step();
      check("final_hold", finalisation_o, 1);
      tag_i = tg;
      end_tag_i = 1'b1;
      step();
      end_tag_i = 1'b0;
    end
    check("done_pulse", done_o, 1);
    step();
    check("done_drop", done_o, 0);
    check("busy_idle", busy_o, 0);
  endtask

  task automatic check_results(input logic [127:0] tg);
    for (int b = 0; b < NPT; b++) check("ct_final", cipher_o[64*b +: 64], exp_ct[b]);
    check("tag_final", tag_o, tg);
  endtask

  initial begin
    reset_i = 1'b0;
    start_i = 1'b0;
    end_initialisation_i = 1'b0;
    end_associate_i = 1'b0;
    cipher_valid_i = 1'b0;
    end_cipher_i = 1'b0;
    end_tag_i = 1'b0;
    cipher_i = '0;
    tag_i = '0;
    plain_text_i = {64'h0000_0000_FFFF_FFFF, 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
    da_i = {64'h5555_6666_7777_8888, 64'h1111_2222_3333_4444};

    repeat (3) step();
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_ct", cipher_o, 0);
    check("rst_tag", tag_o, 0);
    check("rst_core_out", {init_o, associate_data_o, finalisation_o, data_valid_o}, 0);
    check("rst_data", data_o, 0);
    reset_i = 1'b1;
    step();

    cipher_i = '1;
    tag_i = '1;
    cipher_valid_i = 1'b1;
    end_cipher_i = 1'b1;
    end_tag_i = 1'b1;
    step();
    cipher_valid_i = 1'b0;
    end_cipher_i = 1'b0;
    end_tag_i = 1'b0;
    check("idle_tag", tag_o, 0);
    check("idle_ct", cipher_o, 0);
    check("idle_busy", busy_o, 0);

    exp_ct[0] = 64'hA486_E0C2_2C0E_684A;
    exp_ct[1] = 64'h5B79_1F3D_D3F1_97B5;
    exp_ct[2] = 64'hA5A5_A5A5_5A5A_5A5A;
    done_seen = 0;
    start_op();
    check("run1_busy", busy_o, 1);
    serve(TAG1, 1'b0, 1'b1, -1);
    check_results(TAG1);
    check("run1_done_cnt", done_seen, 1);

    plain_text_i = {64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    exp_ct[0] = 64'h5A5A_5A5A_5A5A_5A5A;
    exp_ct[1] = 64'hA5A5_A5A5_A5A5_A5A5;
    exp_ct[2] = 64'hB791_F3DD_3F19_7B55;
    done_seen = 0;
    start_op();
    check("run2_ct_cleared", cipher_o, 0);
    check("run2_tag_cleared", tag_o, 0);
    serve(TAG2, 1'b1, 1'b0, -1);
    check_results(TAG2);
    check("run2_done_cnt", done_seen, 1);

    done_seen = 0;
    start_op();
    serve(TAG1, 1'b0, 1'b0, 1);
    reset_i = 1'b0;
    step();
    reset_i = 1'b1;
    check("abort_busy", busy_o, 0);
    check("abort_ct", cipher_o, 0);
    check("abort_tag", tag_o, 0);
    check("abort_dv", data_valid_o, 0);
    repeat (5) step();
    check("abort_no_done", done_seen, 0);
    check("abort_stay_idle", busy_o, 0);

`ifdef ASCON_SEQ_WATCHDOG_EN
    exp_ct[0] = 64'h5A5A_5A5A_5A5A_5A5A;
    done_seen = 0;
    start_op();
    serve(TAG1, 1'b0, 1'b0, 0);
    repeat (15) step();
    check("wd_not_yet", error_o, 0);
    step();
    check("wd_error", error_o, 1);
    check("wd_core_out", {init_o, associate_data_o, finalisation_o, data_valid_o}, 0);
    check("wd_data", data_o, 0);
    repeat (3) step();
    check("wd_error_hold", error_o, 1);
    check("wd_no_done", done_seen, 0);
    start_op();
    check("wd_clear", error_o, 0);
    check("wd_restart", init_o, 1);
    check("wd_ct_cleared", cipher_o, 0);
    reset_i = 1'b0;
    step();
    reset_i = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
